lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Device-bus responder that turns CPU writes into timed HD44780-style LCD bus cycles.
- Replaces the plain 32-bit latch currently hanging off the device bus at word address 40.
- CPU writes command/data bytes into a FIFO. An FSM drains the FIFO and generates RS/E/D timing. The CPU polls a status word.

Parameters:
- BASE_ADDR, 40: word-aligned device address of the DATA register. STATUS is at BASE_ADDR+4.
- FIFO_DEPTH, 8: entries of 9 bits ({rs, byte}). Must be a power of two, at least 2.
- T_SETUP, 2: clk cycles that RS/D are stable before E rises.
- T_PULSE, 4: clk cycles E is held high.
- T_HOLD, 2: clk cycles RS/D are held after E falls.
- T_CMD, 40: wait cycles after a normal transfer.
- T_CLR, 1600: wait cycles after a clear (0x01) or home (0x02) command with rs=0.

Ports:
- clk  in  1  device-bus clock. All state updates on the falling edge, matching the device-bus timing.
- reset  in  1  asynchronous, active-high.
- bus_addr  in  32  device address. Decoded as {bus_addr[31:2],2'b00}.
- bus_wdata  in  32  write data. [8]=rs, [7:0]=byte. Other bits ignored.
- bus_wen  in  1  write strobe, one cycle per write.
- bus_ren  in  1  read strobe.
- bus_rdata  out  32  registered read data.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  constant 0.
- lcd_e  out  1  enable strobe.
- lcd_d  out  8  LCD data bus.
- irq  out  1  high while the FIFO is empty and the FSM is IDLE.

Behaviour:
- Reset values (asynchronous): bus_rdata=0, lcd_rs=0, lcd_e=0, lcd_d=0, FIFO empty, overflow=0, FSM=IDLE, irq=1. Asserting reset mid-pulse drops lcd_e on the same instant.
- Write to BASE_ADDR:
  - If the FIFO is not full, push {bus_wdata[8], bus_wdata[7:0]}.
  - If the FIFO is full, drop the write and set sticky overflow.
- Write to BASE_ADDR+4: overflow cleared if bus_wdata[0]=1. No other effect.
- Writes to any other address are ignored.
- Read from STATUS (BASE_ADDR+4): bus_rdata = {16'b0, count[7:0], 4'b0, overflow, busy, full, empty}, valid on the next falling edge after bus_ren. Reading does not clear overflow.
- Read from DATA: returns {23'b0, last_sent_rs, last_sent_byte}.
- Read from any other address returns 0.
- bus_rdata holds its value when bus_ren=0.
- busy = (FSM != IDLE).
- count = number of FIFO entries, 0..FIFO_DEPTH.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE: if the FIFO is not empty, pop the entry, drive lcd_rs/lcd_d, load the counter with T_SETUP-1, go to SETUP.
  - SETUP: when the counter reaches 0, set lcd_e=1, load T_PULSE-1, go to PULSE.
  - PULSE: when the counter reaches 0, set lcd_e=0, load T_HOLD-1, go to HOLD.
  - HOLD: when the counter reaches 0, load T_CLR-1 if the entry is rs=0 with byte 0x01 or 0x02, else T_CMD-1; go to WAIT.
  - WAIT: when the counter reaches 0, go to IDLE.
- Counter is wide enough for T_CLR.
- lcd_rs and lcd_d keep their last value in WAIT and IDLE.
- Simultaneous push and pop on the same edge: count unchanged. A push to a full FIFO coinciding with a pop is accepted.
- Pointers wrap modulo FIFO_DEPTH. Count uses one extra bit to distinguish full from empty.
- Minimum time between the starts of back-to-back transfers is T_SETUP+T_PULSE+T_HOLD+T_CMD+1 cycles, including one IDLE cycle.

Optional Feature:
- Macro: LCD_CTRL_NIBBLE_EN.
- Defined:
  - Each FIFO entry is sent as two nibble transfers, high nibble first, on lcd_d[7:4] with lcd_d[3:0]=0.
  - Each nibble runs SETUP/PULSE/HOLD. Between nibbles there is a 1-cycle gap with no WAIT.
  - WAIT runs only after the low nibble.
  - busy stays asserted across both nibbles.
- Not defined: full 8-bit transfer as above. No nibble logic is synthesised.

Test Plan:
- Reset, then read STATUS -> bus_rdata=0x00000001 (empty), lcd_e=0, irq=1.
- Write 0x141 to addr 40 -> lcd_rs=1 and lcd_d=0x41 after the IDLE cycle; lcd_e high for exactly 4 cycles, starting 2 cycles later; busy for 2+4+2+40 cycles; then irq=1.
- Write 0x001 to addr 40 -> lcd_rs=0, lcd_d=0x01; WAIT lasts 1600 cycles before the next pop.
- Write 10 entries back-to-back while the FSM is busy -> the 9th and 10th are dropped once the FIFO is full; STATUS overflow=1 and full=1; write 1 to addr 44 -> overflow=0; the 8 accepted bytes appear on lcd_d in order.
- Assert reset while lcd_e=1 -> lcd_e=0 immediately; FIFO empty; no further pulses after release.
- With LCD_CTRL_NIBBLE_EN defined, write 0x1A5 -> two E pulses with lcd_d=0xA0 then 0x50, lcd_rs=1 on both, single 40-cycle WAIT after the second.

Source files
------------

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: device-bus responder that drains a byte FIFO into HD44780 bus cycles.
// Define LCD_CTRL_NIBBLE_EN to send each entry as two 4-bit transfers on lcd_d[7:4].
module lcd_ctrl #(
  parameter int BASE_ADDR  = 40,
  parameter int FIFO_DEPTH = 8,
  parameter int T_SETUP    = 2,
  parameter int T_PULSE    = 4,
  parameter int T_HOLD     = 2,
  parameter int T_CMD      = 40,
  parameter int T_CLR      = 1600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [7:0]  lcd_d,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(T_CLR + T_CMD + T_SETUP + T_PULSE + T_HOLD + 1);

`ifdef LCD_CTRL_NIBBLE_EN
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
`endif

  state_t        state;
  logic [TW-1:0] tmr;
  logic [8:0]    cur;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   addr;
  logic          is_data;
  logic          is_stat;
  logic          empty;
  logic          full;
  logic          busy;
  logic          pop;
  logic          push;
  logic          wr_data;
  logic          is_clr;
  logic [8:0]    head;
  logic [7:0]    count8;
  logic          unused;
`ifdef LCD_CTRL_NIBBLE_EN
  logic          nib;
`endif

  assign addr    = {bus_addr[31:2], 2'b00};
  assign is_data = addr == 32'(BASE_ADDR);
  assign is_stat = addr == 32'(BASE_ADDR + 4);
  assign empty   = count == '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign busy    = state != IDLE;
  assign pop     = !busy && !empty;
  assign wr_data = bus_wen && is_data;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push    = wr_data && (!full || pop);
  assign head    = mem[rd_ptr];
  assign count8  = 8'(count);
  assign is_clr  = !cur[8] && (cur[7:0] == 8'h01 || cur[7:0] == 8'h02);
  assign irq     = empty && !busy;
  assign lcd_rw  = 1'b0;
  assign unused  = ^{bus_addr[1:0], bus_wdata[31:9]};

  always_ff @(negedge clk) begin
    if (push) mem[wr_ptr] <= bus_wdata[8:0];
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      bus_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr_data && !push) overflow <= 1'b1;
      else if (bus_wen && is_stat && bus_wdata[0]) overflow <= 1'b0;
      if (bus_ren) begin
        unique case (1'b1)
          is_stat: bus_rdata <= {16'b0, count8, 4'b0,
                                 overflow, busy, full, empty};
          is_data: bus_rdata <= {23'b0, cur};
          default: bus_rdata <= '0;
        endcase
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      tmr    <= '0;
      cur    <= '0;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_d  <= '0;
`ifdef LCD_CTRL_NIBBLE_EN
      nib    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            cur    <= head;
            lcd_rs <= head[8];
`ifdef LCD_CTRL_NIBBLE_EN
            lcd_d  <= {head[7:4], 4'b0};
            nib    <= 1'b0;
`else
            lcd_d  <= head[7:0];
`endif
            tmr    <= TW'(T_SETUP - 1);
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == '0) begin
            lcd_e <= 1'b1;
            tmr   <= TW'(T_PULSE - 1);
            state <= PULSE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        PULSE: begin
          if (tmr == '0) begin
            lcd_e <= 1'b0;
            tmr   <= TW'(T_HOLD - 1);
            state <= HOLD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        HOLD: begin
          if (tmr == '0) begin
`ifdef LCD_CTRL_NIBBLE_EN
            if (!nib) begin
              state <= GAP;
            end else begin
              tmr   <= is_clr ? TW'(T_CLR - 1) : TW'(T_CMD - 1);
              state <= WAIT;
            end
`else
            tmr   <= is_clr ? TW'(T_CLR - 1) : TW'(T_CMD - 1);
            state <= WAIT;
`endif
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        WAIT: begin
          if (tmr == '0) state <= IDLE;
          else tmr <= tmr - 1'b1;
        end
`ifdef LCD_CTRL_NIBBLE_EN
        // one dead cycle between nibbles while the low half is set up
        GAP: begin
          lcd_d <= {cur[3:0], 4'b0};
          nib   <= 1'b1;
          tmr   <= TW'(T_SETUP - 1);
          state <= SETUP;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench with a byte scoreboard checked on each lcd_e rise.
// Also builds with LCD_CTRL_NIBBLE_EN to cover the 4-bit transfer mode.
module tb_lcd_ctrl;

  localparam int BASE  = 40;
  localparam int DEPTH = 8;
  localparam int S     = 2;
  localparam int P     = 4;
  localparam int H     = 2;
  localparam int W     = 40;
  localparam int C     = 1600;
`ifdef LCD_CTRL_NIBBLE_EN
  localparam int RPE   = 2;
`else
  localparam int RPE   = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_wen = 1'b0;
  logic        bus_ren = 1'b0;
  logic [31:0] bus_rdata;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_d;
  logic        irq;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int pulses = 0;
  logic [8:0] exp_q[$];
  int rise_q[$];

  lcd_ctrl #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .T_SETUP(S), .T_PULSE(P),
    .T_HOLD(H), .T_CMD(W), .T_CLR(C)
  ) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int xfer(input int w);
`ifdef LCD_CTRL_NIBBLE_EN
    return 2 * (S + P + H) + 1 + w + 1;
`else
    return S + P + H + w + 1;
`endif
  endfunction

  function automatic logic [7:0] first_d(input logic [8:0] e);
`ifdef LCD_CTRL_NIBBLE_EN
    return {e[7:4], 4'b0};
`else
    return e[7:0];
`endif
  endfunction

  task automatic push_exp(input logic [8:0] e);
`ifdef LCD_CTRL_NIBBLE_EN
    exp_q.push_back({e[8], e[7:4], 4'b0});
    exp_q.push_back({e[8], e[3:0], 4'b0});
`else
    exp_q.push_back(e);
`endif
  endtask

  task automatic wr(input int a, input int d);
    bus_addr = a;
    bus_wdata = d;
    bus_wen = 1'b1;
    @(posedge clk);
    bus_wen = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    bus_addr = a;
    bus_ren = 1'b1;
    @(posedge clk);
    bus_ren = 1'b0;
    v = bus_rdata;
  endtask

  task automatic wait_irq(input int lim);
    int k = 0;
    while (!irq && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk("irq_timeout", irq, 1);
  endtask

  // scoreboard consumer: one expected {rs,d} per rising edge of lcd_e
  initial begin : mon
    logic pe;
    int wid;
    logic [8:0] e;
    pe = 1'b0;
    wid = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        pe = 1'b0;
        wid = 0;
      end else begin
        if (lcd_e && !pe) begin
          pulses++;
          rise_q.push_back(cyc);
          wid = 0;
          chk("sb_expect", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("lcd_byte", {lcd_rs, lcd_d}, e);
          end
        end
        if (lcd_e) wid++;
        if (!lcd_e && pe) chk("e_width", wid, P);
        pe = lcd_e;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=%0d expected=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int t0;
    int p0;
    int k;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_d", lcd_d, 0);
    chk("rst_irq", irq, 1);
    chk("rw_zero", lcd_rw, 0);
    reset = 1'b0;
    @(posedge clk);
    rd(BASE + 4, v);
    chk("rst_status", v, 32'h1);

    rise_q.delete();
    push_exp(9'h141);
    wr(BASE, 'h141);
    t0 = cyc;
    chk("irq_low", irq, 0);
    @(posedge clk);
    chk("d_after_idle", lcd_d, first_d(9'h141));
    chk("rs_after_idle", lcd_rs, 1);
    chk("e_not_yet", lcd_e, 0);
    wait_irq(500);
    chk("busy_len", cyc - t0, xfer(W));
    chk("rise_cnt1", rise_q.size(), RPE);
    if (rise_q.size() != 0) chk("e_delay", rise_q[0] - t0, S + 1);

    rise_q.delete();
    push_exp(9'h1A5);
    wr(BASE, 'h1A5);
    t0 = cyc;
    wait_irq(500);
    chk("a5_len", cyc - t0, xfer(W));
    chk("rise_cnt_a5", rise_q.size(), RPE);
`ifdef LCD_CTRL_NIBBLE_EN
    if (rise_q.size() == 2) chk("nib_gap", rise_q[1] - rise_q[0], S + P + H + 1);
`endif

    rise_q.delete();
    push_exp(9'h001);
    wr(BASE, 'h001);
    push_exp(9'h142);
    wr(BASE, 'h142);
    rd(BASE + 4, v);
    chk("status_busy", v, 32'h104);
    wait_irq(6000);
    chk("rise_cnt_clr", rise_q.size(), 2 * RPE);
    if (rise_q.size() == 2 * RPE)
      chk("clr_gap", rise_q[RPE] - rise_q[0], xfer(C));

    rise_q.delete();
    push_exp(9'h002);
    wr(BASE, 'h002);
    push_exp(9'h101);
    wr(BASE, 'h101);
    push_exp(9'h143);
    wr(BASE, 'h143);
    wait_irq(6000);
    chk("rise_cnt_home", rise_q.size(), 3 * RPE);
    if (rise_q.size() == 3 * RPE) begin
      chk("home_gap", rise_q[RPE] - rise_q[0], xfer(C));
      chk("rs1_gap", rise_q[2 * RPE] - rise_q[RPE], xfer(W));
    end
    rd(48, v);
    chk("rd_other", v, 0);
    rd(BASE + 1, v);
    chk("rd_data", v, 32'h143);
    repeat (3) @(posedge clk);
    chk("rdata_hold", bus_rdata, 32'h143);

    wr(48, 'h177);
    @(posedge clk);
    chk("ign_irq", irq, 1);
    rd(BASE + 4, v);
    chk("ign_status", v, 32'h1);

    push_exp(9'h150);
    wr(BASE, 'h150);
    for (int i = 0; i < 10; i++) begin
      if (i < DEPTH) push_exp(9'(9'h160 + i));
      wr(BASE, 'h160 + i);
    end
    rd(BASE + 4, v);
    chk("ovf_status", v, 32'h80E);
    rd(BASE + 4, v);
    chk("ovf_sticky", v, 32'h80E);
    wr(BASE + 4, 0);
    rd(BASE + 4, v);
    chk("ovf_keep", v, 32'h80E);
    wr(BASE + 4, 1);
    rd(BASE + 4, v);
    chk("ovf_clear", v, 32'h806);
    wait_irq(3000);
    chk("sb_drained", exp_q.size(), 0);
    rd(BASE, v);
    chk("last_sent", v, 32'h167);

    push_exp(9'h155);
    wr(BASE, 'h155);
    push_exp(9'h156);
    wr(BASE, 'h156);
    k = 0;
    while (!lcd_e && k < 20) begin
      @(posedge clk);
      k++;
    end
    chk("e_seen", lcd_e, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_e", lcd_e, 0);
    chk("rst_mid_irq", irq, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    reset = 1'b0;
    p0 = pulses;
    repeat (150) @(posedge clk);
    chk("no_pulse", pulses, p0);
    rd(BASE + 4, v);
    chk("rst_mid_status", v, 32'h1);
    rd(BASE, v);
    chk("rst_mid_data", v, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
